pipe_alu: RTL and testbench

- 16-bit integer ALU for the 5-stage pipelined RISC CPU, used in the EX stage.
- Computes the result and the CF/ZF/NF flags combinationally from a 4-bit ALU opcode and two 16-bit operands.
- Also holds a registered copy of the result and flags, so the CPU's select_y debug path can observe the last executed operation.
- The CPU decoder maps ADDC/SUBC to the carry variants using the current CF.

---
 rtl/pipe_alu.sv | 105 ++++++++++
 tb/tb_pipe_alu.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pipe_alu.sv
// 16-bit EX-stage ALU: combinational result and CF/ZF/NF flags, plus a registered
// copy of the last captured operation for the CPU debug view.
module pipe_alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic [WIDTH-1:0] ALUo,
  output logic [2:0]       flags,
  output logic [WIDTH-1:0] ALUo_q,
  output logic [2:0]       flags_q
);

  localparam logic [3:0] OpAdd    = 4'd0;
  localparam logic [3:0] OpAddPls = 4'd1;
  localparam logic [3:0] OpSub    = 4'd2;
  localparam logic [3:0] OpSubMns = 4'd3;
  localparam logic [3:0] OpAnd    = 4'd4;
  localparam logic [3:0] OpOr     = 4'd5;
  localparam logic [3:0] OpXor    = 4'd6;
  localparam logic [3:0] OpNot    = 4'd7;
  localparam logic [3:0] OpSl     = 4'd8;
  localparam logic [3:0] OpSrl    = 4'd9;
  localparam logic [3:0] OpSra    = 4'd10;

  localparam logic [WIDTH:0] One = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic [3:0]       shamt;

  assign shamt = operandB[3:0];

  // Shifts run on a 17-bit value with a guard bit so the last bit shifted out lands
  // in a fixed position; an amount of zero leaves the guard bit clear (CF=0).
  always_comb begin
    ext    = '0;
    result = '0;
    carry  = 1'b0;
    case (opcode)
      OpAdd: begin
        ext    = {1'b0, operandA} + {1'b0, operandB};
        result = ext[WIDTH-1:0];
        carry  = ext[WIDTH];
      end
      OpAddPls: begin
        ext    = {1'b0, operandA} + {1'b0, operandB} + One;
        result = ext[WIDTH-1:0];
        carry  = ext[WIDTH];
      end
      OpSub: begin
        ext    = {1'b0, operandA} - {1'b0, operandB};
        result = ext[WIDTH-1:0];
        carry  = ext[WIDTH];
      end
      OpSubMns: begin
        ext    = {1'b0, operandA} - {1'b0, operandB} - One;
        result = ext[WIDTH-1:0];
        carry  = ext[WIDTH];
      end
      OpAnd: result = operandA & operandB;
      OpOr:  result = operandA | operandB;
      OpXor: result = operandA ^ operandB;
      OpNot: result = ~operandA;
      OpSl: begin
        ext    = {1'b0, operandA} << shamt;
        result = ext[WIDTH-1:0];
        carry  = ext[WIDTH];
      end
      OpSrl: begin
        ext    = {operandA, 1'b0} >> shamt;
        result = ext[WIDTH:1];
        carry  = ext[0];
      end
      OpSra: begin
        ext    = $unsigned($signed({operandA, 1'b0}) >>> shamt);
        result = ext[WIDTH:1];
        carry  = ext[0];
      end
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

  assign ALUo  = result;
  assign flags = {result[WIDTH-1], (result == '0), carry};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ALUo_q  <= '0;
      flags_q <= '0;
    end else if (en) begin
      ALUo_q  <= ALUo;
      flags_q <= flags;
    end
  end

endmodule

// File: tb/tb_pipe_alu.sv
// Directed bench for pipe_alu: combinational opcode vectors, then capture/hold/reset
// behaviour of the registered outputs.
module tb_pipe_alu;

  logic        clock;
  logic        reset;
  logic        en;
  logic [3:0]  opcode;
  logic [15:0] operandA;
  logic [15:0] operandB;
  logic [15:0] ALUo;
  logic [2:0]  flags;
  logic [15:0] ALUo_q;
  logic [2:0]  flags_q;

  int checks   = 0;
  int failures = 0;

  pipe_alu #(.WIDTH(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .opcode   (opcode),
    .operandA (operandA),
    .operandB (operandB),
    .ALUo     (ALUo),
    .flags    (flags),
    .ALUo_q   (ALUo_q),
    .flags_q  (flags_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic apply(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    opcode   = op;
    operandA = a;
    operandB = b;
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    opcode   = 4'd0;
    operandA = '0;
    operandB = '0;
    #2;
    check("reset_alu_q", ALUo_q, 0);
    check("reset_flags_q", flags_q, 0);
    @(negedge clock);
    reset = 1'b0;

    apply(4'd0, 16'hFFFF, 16'h0001);
    check("add_carry_res", ALUo, 16'h0000);
    check("add_carry_flg", flags, 3'b011);
    apply(4'd1, 16'h0001, 16'h0001);
    check("addpls_res", ALUo, 16'h0003);
    check("addpls_flg", flags, 3'b000);
    apply(4'd2, 16'h0005, 16'h0007);
    check("sub_borrow_res", ALUo, 16'hFFFE);
    check("sub_borrow_flg", flags, 3'b101);
    apply(4'd3, 16'h0007, 16'h0005);
    check("submns_res", ALUo, 16'h0001);
    check("submns_flg", flags, 3'b000);
    apply(4'd3, 16'h0005, 16'h0005);
    check("submns_eq_res", ALUo, 16'hFFFF);
    check("submns_eq_flg", flags, 3'b101);
    apply(4'd3, 16'h1234, 16'hFFFF);
    check("submns_bmax_res", ALUo, 16'h1234);
    check("submns_bmax_flg", flags, 3'b001);

    apply(4'd4, 16'hF0F0, 16'h0FF0);
    check("and_res", ALUo, 16'h00F0);
    check("and_flg", flags, 3'b000);
    apply(4'd5, 16'h0000, 16'h1234);
    check("or_res", ALUo, 16'h1234);
    apply(4'd6, 16'hABCD, 16'hABCD);
    check("xor_res", ALUo, 16'h0000);
    check("xor_flg", flags, 3'b010);
    apply(4'd7, 16'h0000, 16'h5555);
    check("not_res", ALUo, 16'hFFFF);
    check("not_flg", flags, 3'b100);

    apply(4'd8, 16'h8001, 16'h0001);
    check("sl_res", ALUo, 16'h0002);
    check("sl_flg", flags, 3'b001);
    apply(4'd8, 16'h0003, 16'h000F);
    check("sl15_res", ALUo, 16'h8000);
    check("sl15_flg", flags, 3'b101);
    apply(4'd9, 16'h8001, 16'h0004);
    check("srl_res", ALUo, 16'h0800);
    check("srl_flg", flags, 3'b000);
    apply(4'd9, 16'h8001, 16'h0001);
    check("srl1_flg", flags, 3'b001);
    apply(4'd10, 16'h8000, 16'h000F);
    check("sra_res", ALUo, 16'hFFFF);
    check("sra_flg", flags, 3'b100);
    apply(4'd10, 16'h8008, 16'h0004);
    check("sra4_res", ALUo, 16'hF800);
    check("sra4_flg", flags, 3'b101);
    // Amount taken from B[3:0] only; B=0x0010 means shift by zero.
    apply(4'd8, 16'hC001, 16'h0010);
    check("sl0_res", ALUo, 16'hC001);
    check("sl0_flg", flags, 3'b100);
    apply(4'd9, 16'h8001, 16'h0000);
    check("srl0_res", ALUo, 16'h8001);
    check("srl0_flg", flags, 3'b100);
    apply(4'd10, 16'h0001, 16'h0000);
    check("sra0_res", ALUo, 16'h0001);
    check("sra0_flg", flags, 3'b000);

    apply(4'd13, 16'hFFFF, 16'hFFFF);
    check("undef_res", ALUo, 16'h0000);
    check("undef_flg", flags, 3'b010);

    // Registered outputs: capture, hold, asynchronous reset.
    @(negedge clock);
    en = 1'b1;
    apply(4'd0, 16'h0002, 16'h0003);
    @(posedge clock);
    #1;
    check("cap_alu_q", ALUo_q, 16'h0005);
    check("cap_flags_q", flags_q, 3'b000);

    @(negedge clock);
    en = 1'b0;
    apply(4'd2, 16'h0005, 16'h0007);
    @(posedge clock);
    #1;
    check("hold_alu_q", ALUo_q, 16'h0005);
    check("hold_flags_q", flags_q, 3'b000);

    @(negedge clock);
    en = 1'b1;
    @(posedge clock);
    #1;
    check("cap2_alu_q", ALUo_q, 16'hFFFE);
    check("cap2_flags_q", flags_q, 3'b101);

    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_alu_q", ALUo_q, 16'h0000);
    check("async_rst_flags_q", flags_q, 3'b000);
    check("rst_comb_res", ALUo, 16'hFFFE);
    check("rst_comb_flg", flags, 3'b101);
    @(posedge clock);
    #1;
    check("rst_held_alu_q", ALUo_q, 16'h0000);
    check("rst_held_flags_q", flags_q, 3'b000);

    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("post_rst_alu_q", ALUo_q, 16'hFFFE);
    check("post_rst_flags_q", flags_q, 3'b101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
